// File: rtl/tensor_streamer.sv
// Captures a whole flat tensor on start and replays it, one element per valid/ready handshake.
// Latency: first element valid the cycle after start; done pulses the cycle after the last handshake.
module tensor_streamer #(
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 1,
    parameter int HEIGHT     = 4,
    parameter int WIDTH      = 4,
    parameter int DATA_WIDTH = 32,
    localparam int TOTAL     = BATCH_SIZE * CHANNELS * HEIGHT * WIDTH,
    localparam int IDX_W     = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [TOTAL*DATA_WIDTH-1:0] tensor_flat,
    output logic                        busy,
    output logic                        done,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic [IDX_W-1:0]            m_index,
    output logic                        m_last
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    done_q, done_d;
    logic                    load;
    logic [DATA_WIDTH-1:0]   elem_q [TOTAL];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                // Also the done cycle, so a start here chains streams with a one-cycle gap.
                if (start) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            STREAM: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Private copy so upstream may reuse tensor_flat as soon as start is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TOTAL; i++) elem_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < TOTAL; i++) elem_q[i] <= tensor_flat[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign busy    = (state_q == STREAM);
    assign m_valid = (state_q == STREAM);
    assign done    = done_q;
    assign m_index = idx_q;
    assign m_data  = elem_q[idx_q];
    assign m_last  = m_valid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_tensor_streamer.sv
// Scoreboarded bench for tensor_streamer with a 1x1x2x2 tensor of 8-bit elements.
module tb_tensor_streamer;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] tensor_flat;
    logic        busy, done, m_valid, m_ready, m_last;
    logic [7:0]  m_data;
    logic [1:0]  m_index;

    typedef struct {
        logic [7:0] d;
        logic [1:0] i;
        logic       l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests    = 0;
    int   fails    = 0;
    int   done_cnt = 0;

    tensor_streamer #(
        .BATCH_SIZE(1), .CHANNELS(1), .HEIGHT(2), .WIDTH(2), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tensor_flat(tensor_flat),
        .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_index(m_index), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Every accepted element must match the oldest expected entry.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            tests++;
            if (m_valid !== 1'b0) begin
                fails++;
                $display("FAIL done_with_valid: m_valid=%b required 0", m_valid);
            end
        end
        if (m_valid && m_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_elem: data=%h idx=%0d, nothing expected", m_data, m_index);
            end else begin
                mon_e = sb.pop_front();
                if ({m_data, m_index, m_last} !== {mon_e.d, mon_e.i, mon_e.l}) begin
                    fails++;
                    $display("FAIL elem: data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                             m_data, m_index, m_last, mon_e.d, mon_e.i, mon_e.l);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tensor(input logic [31:0] t);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.d = t[i*DW +: DW];
            e.i = 2'(i);
            e.l = (i == 3);
            sb.push_back(e);
        end
    endtask

    // Leaves the bench just after the capturing edge, i.e. in cycle 1 of the stream.
    task automatic issue(input logic [31:0] t);
        step();
        start       = 1'b1;
        tensor_flat = t;
        push_tensor(t);
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; m_ready = 1'b0; tensor_flat = '0;
        #12;
        tests++;
        if ({busy, done, m_valid, m_data, m_index, m_last} !== 14'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b valid=%b data=%h idx=%0d last=%b required all 0",
                     busy, done, m_valid, m_data, m_index, m_last);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy, m_valid);
        end
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        m_ready = 1'b1;
        issue(32'h04030201);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            tests++;
            if (m_valid !== 1'((c <= 4)) || busy !== 1'((c <= 4)) || done !== 1'((c == 5))) begin
                fails++;
                $display("FAIL basic_ctrl c%0d: valid=%b busy=%b done=%b required %b %b %b",
                         c, m_valid, busy, done, c <= 4, c <= 4, c == 5);
            end
            step();
        end
        tests++;
        if (sb.size() != 0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL basic_end: left=%0d dones=%0d required 0 1", sb.size(), done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt;
        int hs = 0;
        int hs_cycle = 0;
        m_ready = 1'b0;
        issue(32'h04030201);
        for (int c = 1; c <= 13; c++) begin
            m_ready = (c <= 3) ? 1'b0 : 1'(((c - 4) % 2) == 0);
            @(negedge clk);
            if (c <= 3) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== 8'h01 || m_index !== 2'd0) begin
                    fails++;
                    $display("FAIL stall_hold c%0d: valid=%b data=%h idx=%0d required 1 01 0",
                             c, m_valid, m_data, m_index);
                end
            end
            tests++;
            if (done !== 1'((hs == 4 && c == hs_cycle + 1))) begin
                fails++;
                $display("FAIL bp_done c%0d: done=%b required %b", c, done, hs == 4 && c == hs_cycle + 1);
            end
            if (m_valid && m_ready) begin
                hs++;
                hs_cycle = c;
            end
            step();
        end
        m_ready = 1'b1;
        tests++;
        if (hs != 4 || sb.size() != 0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL bp_count: hs=%0d left=%0d dones=%0d required 4 0 1", hs, sb.size(), done_cnt - d0);
        end
    endtask

    task automatic test_start_while_busy();
        int d0 = done_cnt;
        m_ready = 1'b1;
        issue(32'h04030201);
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin
                start = 1'b1;
                tensor_flat = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (c >= 5) begin
                tests++;
                if (m_valid !== 1'b0 || done !== 1'((c == 5))) begin
                    fails++;
                    $display("FAIL busy_start c%0d: valid=%b done=%b required 0 %b", c, m_valid, done, c == 5);
                end
            end
            step();
        end
        tests++;
        if (sb.size() != 0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL busy_start_end: left=%0d dones=%0d required 0 1", sb.size(), done_cnt - d0);
        end
    endtask

    task automatic test_capture_isolation();
        int d0 = done_cnt;
        m_ready = 1'b1;
        issue(32'h04030201);
        tensor_flat = 32'hFFFFFFFF;
        for (int c = 1; c <= 6; c++) begin
            step();
        end
        tests++;
        if (sb.size() != 0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL isolation_end: left=%0d dones=%0d required 0 1", sb.size(), done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        m_ready = 1'b1;
        issue(32'h04030201);
        for (int c = 1; c <= 11; c++) begin
            if (c == 5) begin
                start = 1'b1;
                tensor_flat = 32'h0A0B0C0D;
                push_tensor(32'h0A0B0C0D);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (c == 5 || c == 10) begin
                tests++;
                if (done !== 1'b1 || m_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_done c%0d: done=%b valid=%b required 1 0", c, done, m_valid);
                end
            end
            if (c == 6) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== 8'h0D || m_index !== 2'd0) begin
                    fails++;
                    $display("FAIL b2b_first: valid=%b data=%h idx=%0d required 1 0d 0", m_valid, m_data, m_index);
                end
            end
            if (c >= 7 && c <= 9) begin
                tests++;
                if (m_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_gap c%0d: valid=%b required 1", c, m_valid);
                end
            end
            step();
        end
        tests++;
        if (sb.size() != 0 || done_cnt - d0 != 2) begin
            fails++;
            $display("FAIL b2b_end: left=%0d dones=%0d required 0 2", sb.size(), done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_stream();
        int d0 = done_cnt;
        m_ready = 1'b1;
        issue(32'h04030201);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_index !== 2'd0) begin
            fails++;
            $display("FAIL abort: valid=%b busy=%b done=%b idx=%0d required 0 0 0 0", m_valid, busy, done, m_index);
        end
        tests++;
        if (sb.size() != 2) begin
            fails++;
            $display("FAIL abort_progress: left=%0d required 2", sb.size());
        end
        sb.delete();
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        tests++;
        if (done_cnt != d0) begin
            fails++;
            $display("FAIL abort_no_done: dones=%0d required 0", done_cnt - d0);
        end
        issue(32'h44332211);
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b1 || m_index !== 2'd0 || m_data !== 8'h11) begin
            fails++;
            $display("FAIL restart: valid=%b idx=%0d data=%h required 1 0 11", m_valid, m_index, m_data);
        end
        for (int c = 1; c <= 6; c++) begin
            step();
        end
        tests++;
        if (sb.size() != 0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL restart_end: left=%0d dones=%0d required 0 1", sb.size(), done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_while_busy();
        test_capture_isolation();
        test_back_to_back();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
